// File: rtl/commit_regfile_pkg.sv
// Shared types and sizing for the rename/commit register file, the ROB and the issue queue.
package commit_regfile_pkg;

    localparam int RF_NREG  = 32;   // architectural registers, x0 hardwired to zero
    localparam int RF_ROB_W = 5;    // ROB tag width (32-entry ROB)
    localparam int RF_XLEN  = 32;   // data width
    localparam int RF_IDX_W = 5;    // register number width

    // Issue-side rename request plus the two source lookups.
    typedef struct packed {
        logic                write;
        logic [RF_IDX_W-1:0] rd;
        logic [RF_ROB_W-1:0] rob_index;
        logic [RF_IDX_W-1:0] lookup_regfile_1;
        logic [RF_IDX_W-1:0] lookup_regfile_2;
    } IQtoRF;

    // Commit-side writeback from the ROB.
    typedef struct packed {
        logic                commit;
        logic [RF_IDX_W-1:0] rd;
        logic [RF_ROB_W-1:0] rob_index;
        logic [RF_XLEN-1:0]  value;
    } rob_to_regfile;

    // Operand results returned to the issue queue.
    typedef struct packed {
        logic [RF_XLEN-1:0]  val_1;
        logic                busy_1;
        logic [RF_ROB_W-1:0] tag_1;
        logic [RF_XLEN-1:0]  val_2;
        logic                busy_2;
        logic [RF_ROB_W-1:0] tag_2;
    } RFtoIQ;

endpackage

// File: rtl/commit_regfile_rf_lookup_port.sv
// One combinational read port with same-cycle commit bypass.
module rf_lookup_port
    import commit_regfile_pkg::*;
#(
    parameter int ROB_W = RF_ROB_W
) (
    input  logic [RF_IDX_W-1:0] src,
    input  logic [RF_XLEN-1:0]  st_val,
    input  logic                st_busy,
    input  logic [ROB_W-1:0]    st_tag,
    input  logic                byp_valid,
    input  logic [RF_IDX_W-1:0] byp_rd,
    input  logic [ROB_W-1:0]    byp_tag,
    input  logic [RF_XLEN-1:0]  byp_val,
    output logic [RF_XLEN-1:0]  val,
    output logic                busy,
    output logic [ROB_W-1:0]    tag
);

    // Stored entry by default; a commit landing this cycle overrides the value,
    // and clears busy only when it is the producer the entry is waiting on.
    always_comb begin
        val  = st_val;
        busy = st_busy;
        tag  = st_tag;
        if (src == '0) begin
            val  = '0;
            busy = 1'b0;
            tag  = '0;
        end else if (byp_valid && (byp_rd == src)) begin
            val = byp_val;
            if (st_tag == byp_tag)
                busy = 1'b0;
        end
    end

endmodule

// File: rtl/commit_regfile.sv
// Architectural register file with rename state (busy/tag) and a retire counter.
module commit_regfile
    import commit_regfile_pkg::*;
#(
    parameter int NREG  = RF_NREG,
    parameter int ROB_W = RF_ROB_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  IQtoRF         iq_rf,
    input  rob_to_regfile rob_rf,
    input  logic          flush,
    output RFtoIQ         rf_iq,
    output logic [63:0]   retired
);

    logic [RF_XLEN-1:0] val_q [NREG];
    logic [ROB_W-1:0]   tag_q [NREG];
    logic [NREG-1:0]    busy_q;

    logic is_en;
    logic cm_en;
    logic byp_valid;

    assign is_en     = iq_rf.write && (iq_rf.rd != '0);
    assign cm_en     = rob_rf.commit && (rob_rf.rd != '0);
    // A commit presented while reset is held must not leak onto the lookups.
    assign byp_valid = rob_rf.commit && rst_n;

    // Register state: commit writes first, then flush or issue override the rename state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (cm_en) begin
                val_q[rob_rf.rd] <= rob_rf.value;
                if (tag_q[rob_rf.rd] == rob_rf.rob_index)
                    busy_q[rob_rf.rd] <= 1'b0;
            end
            if (flush) begin
                busy_q <= '0;
            end else if (is_en) begin
                busy_q[iq_rf.rd] <= 1'b1;
                tag_q[iq_rf.rd]  <= iq_rf.rob_index;
            end
        end
    end

    // Every commit retires an instruction, including x0 and stale commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retired <= '0;
        else if (rob_rf.commit)
            retired <= retired + 64'd1;
    end

    logic [RF_XLEN-1:0] val_1, val_2;
    logic               busy_1, busy_2;
    logic [ROB_W-1:0]   tag_1, tag_2;

    rf_lookup_port #(.ROB_W(ROB_W)) u_port_1 (
        .src       (iq_rf.lookup_regfile_1),
        .st_val    (val_q[iq_rf.lookup_regfile_1]),
        .st_busy   (busy_q[iq_rf.lookup_regfile_1]),
        .st_tag    (tag_q[iq_rf.lookup_regfile_1]),
        .byp_valid (byp_valid),
        .byp_rd    (rob_rf.rd),
        .byp_tag   (rob_rf.rob_index),
        .byp_val   (rob_rf.value),
        .val       (val_1),
        .busy      (busy_1),
        .tag       (tag_1)
    );

    rf_lookup_port #(.ROB_W(ROB_W)) u_port_2 (
        .src       (iq_rf.lookup_regfile_2),
        .st_val    (val_q[iq_rf.lookup_regfile_2]),
        .st_busy   (busy_q[iq_rf.lookup_regfile_2]),
        .st_tag    (tag_q[iq_rf.lookup_regfile_2]),
        .byp_valid (byp_valid),
        .byp_rd    (rob_rf.rd),
        .byp_tag   (rob_rf.rob_index),
        .byp_val   (rob_rf.value),
        .val       (val_2),
        .busy      (busy_2),
        .tag       (tag_2)
    );

    // Pack both read ports into the response struct.
    always_comb begin
        rf_iq        = '0;
        rf_iq.val_1  = val_1;
        rf_iq.busy_1 = busy_1;
        rf_iq.tag_1  = tag_1;
        rf_iq.val_2  = val_2;
        rf_iq.busy_2 = busy_2;
        rf_iq.tag_2  = tag_2;
    end

endmodule

// File: tb/tb_commit_regfile.sv
// Directed bench for commit_regfile: rename, commit, bypass, flush, reset and retire count.
module tb_commit_regfile;
    import commit_regfile_pkg::*;

    logic          clk;
    logic          rst_n;
    IQtoRF         iq;
    rob_to_regfile rob;
    logic          flush;
    RFtoIQ         rf;
    logic [63:0]   retired;

    int checks = 0;
    int errors = 0;

    commit_regfile dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .iq_rf   (iq),
        .rob_rf  (rob),
        .flush   (flush),
        .rf_iq   (rf),
        .retired (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ev;
        rst_n = 1'b0;
        iq    = '0;
        rob   = '0;
        flush = 1'b0;

        // reset state
        #3;
        chk("rst_retired", retired, 64'd0);
        chk("rst_val1", rf.val_1, 0);
        chk("rst_busy1", rf.busy_1, 0);
        chk("rst_tag1", rf.tag_1, 0);
        cyc();
        rst_n = 1'b1;
        #1;

        // issue rd=3 rob=0, visible next cycle
        iq.write = 1'b1; iq.rd = 5'd3; iq.rob_index = 5'd0; iq.lookup_regfile_1 = 5'd3;
        #1;
        chk("issue_not_same_cycle", rf.busy_1, 0);
        cyc();
        iq.write = 1'b0;
        #1;
        chk("issue_busy1", rf.busy_1, 1);
        chk("issue_tag1", rf.tag_1, 0);
        chk("issue_val1", rf.val_1, 0);
        chk("x0_val2", rf.val_2, 0);

        // commit with same-cycle lookup bypass
        rob.commit = 1'b1; rob.rd = 5'd3; rob.rob_index = 5'd0; rob.value = 32'd156;
        #1;
        chk("byp_val1", rf.val_1, 156);
        chk("byp_busy1", rf.busy_1, 0);
        cyc();
        rob = '0;
        #1;
        chk("commit_val1", rf.val_1, 156);
        chk("commit_busy1", rf.busy_1, 0);

        // two renames of rd3, stale commit then matching commit
        iq.write = 1'b1; iq.rd = 5'd3; iq.rob_index = 5'd0;
        cyc();
        iq.rob_index = 5'd1;
        cyc();
        iq.write = 1'b0;
        rob.commit = 1'b1; rob.rd = 5'd3; rob.rob_index = 5'd0; rob.value = 32'd156;
        #1;
        chk("stale_byp_busy1", rf.busy_1, 1);
        chk("stale_byp_tag1", rf.tag_1, 1);
        cyc();
        rob = '0;
        #1;
        chk("stale_val1", rf.val_1, 156);
        chk("stale_busy1", rf.busy_1, 1);
        chk("stale_tag1", rf.tag_1, 1);
        rob.commit = 1'b1; rob.rd = 5'd3; rob.rob_index = 5'd1; rob.value = 32'd301;
        cyc();
        rob = '0;
        #1;
        chk("match_val1", rf.val_1, 301);
        chk("match_busy1", rf.busy_1, 0);
        chk("match_tag1", rf.tag_1, 1);

        // same-cycle issue and commit to rd7
        iq.lookup_regfile_2 = 5'd7;
        iq.write = 1'b1; iq.rd = 5'd7; iq.rob_index = 5'd9;
        rob.commit = 1'b1; rob.rd = 5'd7; rob.rob_index = 5'd4; rob.value = 32'd207;
        #1;
        chk("both_byp_val2", rf.val_2, 207);
        chk("both_byp_busy2", rf.busy_2, 0);
        cyc();
        iq.write = 1'b0;
        rob = '0;
        #1;
        chk("both_val2", rf.val_2, 207);
        chk("both_busy2", rf.busy_2, 1);
        chk("both_tag2", rf.tag_2, 9);

        // rename every register, then flush with a same-cycle issue and commit
        for (int r = 1; r < 32; r++) begin
            iq.write = 1'b1; iq.rd = r[4:0]; iq.rob_index = r[4:0];
            cyc();
        end
        iq.write = 1'b0;
        iq.lookup_regfile_1 = 5'd31;
        #1;
        chk("pre_flush_busy31", rf.busy_1, 1);
        chk("pre_flush_tag31", rf.tag_1, 31);
        flush = 1'b1;
        iq.write = 1'b1; iq.rd = 5'd5; iq.rob_index = 5'd20;
        rob.commit = 1'b1; rob.rd = 5'd10; rob.rob_index = 5'd3; rob.value = 32'hAAA;
        cyc();
        flush = 1'b0;
        iq.write = 1'b0;
        rob = '0;
        for (int r = 1; r < 32; r++) begin
            iq.lookup_regfile_1 = r[4:0];
            #1;
            ev = (r == 3) ? 32'd301 : (r == 7) ? 32'd207 : (r == 10) ? 32'hAAA : 32'd0;
            chk($sformatf("flush_busy_r%0d", r), rf.busy_1, 0);
            chk($sformatf("flush_val_r%0d", r), rf.val_1, ev);
        end
        chk("retired_5", retired, 64'd5);

        // reset pulse between edges clears counter, then 40 commits incl. x0
        cyc();
        rst_n = 1'b0;
        #1;
        chk("pulse_retired", retired, 64'd0);
        iq.lookup_regfile_1 = 5'd3;
        #1;
        chk("pulse_val_r3", rf.val_1, 0);
        rst_n = 1'b1;
        iq.lookup_regfile_1 = 5'd0;
        cyc();
        for (int i = 0; i < 40; i++) begin
            rob.commit = 1'b1; rob.rd = i[4:0] & 5'd7; rob.rob_index = i[4:0]; rob.value = 32'd100 + i;
            #1;
            chk($sformatf("x0_commit_%0d", i), rf.val_1, 0);
            cyc();
        end
        rob = '0;
        #1;
        chk("retired_40", retired, 64'd40);
        iq.lookup_regfile_2 = 5'd7;
        #1;
        chk("last_val_r7", rf.val_2, 32'd139);
        rst_n = 1'b0;
        rob.commit = 1'b1; rob.rd = 5'd7; rob.rob_index = 5'd0; rob.value = 32'd55;
        #1;
        chk("mid_rst_retired", retired, 64'd0);
        chk("mid_rst_val2", rf.val_2, 0);
        chk("mid_rst_busy2", rf.busy_2, 0);
        rob = '0;
        rst_n = 1'b1;
        cyc();
        chk("post_rst_retired", retired, 64'd0);
        chk("post_rst_val2", rf.val_2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
